// File: rtl/sobel_frame_streamer.sv
// sobel_frame_streamer: reads a finished Sobel frame from BRAM1 port 2 and
// streams it out over valid/ready with SOF/EOL/EOF markers. A 2-entry FIFO
// absorbs the 1-cycle BRAM read latency so backpressure never drops or
// duplicates a pixel.
module sobel_frame_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int LINE_WIDTH = 98
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_num_cnt,
    output logic                  b1_ce2,
    output logic                  b1_we2,
    output logic [ADDR_WIDTH-1:0] b1_addr2,
    output logic [DATA_WIDTH-1:0] b1_d2,
    input  logic [DATA_WIDTH-1:0] b1_q2,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_sof,
    output logic                  o_eol,
    output logic                  o_eof,
    output logic                  o_idle,
    output logic                  o_done
);

    localparam int COL_W = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] num_cnt;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] cap_idx;
    logic [COL_W-1:0]      col;
    logic                  inflight;

    // 2-entry FIFO storage; markers travel with the pixel
    logic [DATA_WIDTH-1:0] fifo_data [0:1];
    logic [1:0]            fifo_sof;
    logic [1:0]            fifo_eol;
    logic [1:0]            fifo_eof;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            occ;

    logic                  pop;
    logic                  push;
    logic                  push_ok;
    logic                  issue;
    logic [2:0]            need;
    logic [2:0]            limit;
    logic                  cap_eof;
    logic                  cap_eol;
    logic                  start_frame;

    assign o_valid  = (occ != 2'd0);
    assign pop      = o_valid & i_ready;
    assign push     = inflight;
    // A push into a full FIFO is only legal if the head leaves this cycle;
    // the issue rule makes the other case unreachable.
    assign push_ok  = push & ((occ != 2'd2) | pop);

    // Issue only if the FIFO can still hold this read plus the one in flight,
    // crediting the entry that leaves this cycle.
    assign need     = {1'b0, occ} + {2'b00, inflight};
    assign limit    = 3'd2 + {2'b00, pop};
    assign issue    = (state == STREAM) && (rd_addr < num_cnt) && (need < limit);

    assign b1_ce2   = issue;
    assign b1_addr2 = rd_addr;
    assign b1_we2   = 1'b0;
    assign b1_d2    = '0;

    assign start_frame = (state == IDLE) && i_start;

    // Markers are derived from the capture index, not the read address, so
    // they stay aligned with the data entering the FIFO.
    assign cap_eof  = (cap_idx == num_cnt - 1'b1);
    assign cap_eol  = (col == COL_W'(LINE_WIDTH - 1)) || cap_eof;

    // Head of FIFO is presented only while valid; otherwise outputs read 0
    assign o_data   = o_valid ? fifo_data[rd_ptr] : '0;
    assign o_sof    = o_valid & fifo_sof[rd_ptr];
    assign o_eol    = o_valid & fifo_eol[rd_ptr];
    assign o_eof    = o_valid & fifo_eof[rd_ptr];

    assign o_idle   = (state == IDLE);
    assign o_done   = (state == DONE);

    // Frame control FSM and read address generator
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            num_cnt <= '0;
            rd_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        rd_addr <= '0;
                        if (i_num_cnt != '0) begin
                            num_cnt <= i_num_cnt;
                            state   <= STREAM;
                        end else begin
                            state   <= DONE;
                        end
                    end
                end
                STREAM: begin
                    if (issue)
                        rd_addr <= rd_addr + 1'b1;
                    if (rd_addr == num_cnt)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (pop && o_eof)
                        state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read-latency tracking and capture-side marker counters
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
            cap_idx  <= '0;
            col      <= '0;
        end else begin
            inflight <= issue;
            if (start_frame) begin
                cap_idx <= '0;
                col     <= '0;
            end else if (push) begin
                cap_idx <= cap_idx + 1'b1;
                col     <= cap_eol ? '0 : col + 1'b1;
            end
        end
    end

    // 2-entry FIFO: write captured BRAM data at tail, advance head on handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            occ          <= 2'd0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_sof     <= '0;
            fifo_eol     <= '0;
            fifo_eof     <= '0;
        end else begin
            if (push_ok) begin
                fifo_data[wr_ptr] <= b1_q2;
                fifo_sof[wr_ptr]  <= (cap_idx == '0);
                fifo_eol[wr_ptr]  <= cap_eol;
                fifo_eof[wr_ptr]  <= cap_eof;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push_ok, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_frame_streamer.sv
// Self-checking bench for sobel_frame_streamer: BRAM1 model with 1-cycle
// read latency, a frame-level reference model of the pixel/marker stream,
// and an occupancy model derived purely from observed issues and handshakes.
module tb_sobel_frame_streamer;

    localparam int DW = 8;
    localparam int AW = 12;
    localparam int LW = 98;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic [AW-1:0] i_num_cnt;
    logic          b1_ce2;
    logic          b1_we2;
    logic [AW-1:0] b1_addr2;
    logic [DW-1:0] b1_d2;
    logic [DW-1:0] b1_q2;
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_data;
    logic          o_sof;
    logic          o_eol;
    logic          o_eof;
    logic          o_idle;
    logic          o_done;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_checks = 0;
    int n_fail   = 0;

    sobel_frame_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_num_cnt(i_num_cnt),
        .b1_ce2(b1_ce2), .b1_we2(b1_we2), .b1_addr2(b1_addr2), .b1_d2(b1_d2),
        .b1_q2(b1_q2), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
        .o_sof(o_sof), .o_eol(o_eol), .o_eof(o_eof), .o_idle(o_idle), .o_done(o_done)
    );

    always #5 clk = ~clk;

    // BRAM1 port 2: synchronous read, data valid the cycle after ce
    always @(posedge clk) begin
        if (b1_ce2)
            b1_q2 <= mem[b1_addr2];
    end

    typedef struct {
        int n;          // pixels in frame
        int pct;        // i_ready probability in percent
        int restart_at; // cycle of a stray i_start pulse, -1 for none
        int rand_mem;   // 0: mem = addr[7:0], 1: random contents
        int exp_first;  // expected first o_valid cycle, -1 = don't care
        int exp_done;   // expected o_done cycle, -1 = don't care
        int exp_eols;   // expected number of eol-marked pixels
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference pixel k of an n-pixel frame: {data, sof, eol, eof}
    function automatic logic [DW+2:0] exp_pix(input int k, input int n);
        logic last;
        last = (k == n - 1);
        return {mem[k], (k == 0), ((k % LW) == LW - 1) || last, last};
    endfunction

    task automatic fill_mem(input int rnd);
        for (int a = 0; a < (1 << AW); a++)
            mem[a] = rnd ? DW'($urandom) : DW'(a);
    endtask

    // Run one frame from IDLE; cycle 0 is the i_start cycle.
    task automatic run_frame(input int n, input int pct, input int restart_at,
                             output int first_v, output int done_c,
                             output int eols, output int npix);
        int issued = 0, cap = 0, ce_prev = 0, eof_c = -1, fifo_m, exp_dc;
        int budget = 20 * n + 60;
        bit pop, finished = 0;
        first_v = -1; done_c = -1; eols = 0; npix = 0;
        for (int c = 0; c < budget && !finished; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                i_start   = 1'b1;
                i_num_cnt = AW'(n);
            end else begin
                i_start   = (c == restart_at);
                i_num_cnt = AW'($urandom);
            end
            i_ready = ($urandom_range(99) < pct);
            @(negedge clk);
            fifo_m = cap - npix;
            chk("valid_vs_occupancy", o_valid, fifo_m > 0);
            if (fifo_m > 2)
                chk("fifo_overflow", fifo_m, 2);
            if (o_valid) begin
                if (first_v < 0) first_v = c;
                if (npix < n)
                    chk("head_pixel", {o_data, o_sof, o_eol, o_eof}, exp_pix(npix, n));
                else
                    chk("extra_pixel", npix, n - 1);
            end
            if (b1_ce2) begin
                chk("read_addr", b1_addr2, AW'(issued));
                if (issued >= n) chk("read_past_end", issued, n - 1);
                issued++;
            end
            pop = o_valid && i_ready;
            if (pop) begin
                if (o_eol) eols++;
                if (npix == n - 1) eof_c = c;
                npix++;
            end
            if (o_done) begin
                done_c = c;
                exp_dc = (n == 0) ? 1 : eof_c + 1;
                chk("done_timing", done_c, exp_dc);
                finished = 1;
            end
            cap += ce_prev;
            ce_prev = b1_ce2;
        end
        i_start = 1'b0;
        if (!finished)
            chk("frame_timeout", 0, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_after_done", {o_idle, o_done, o_valid}, 3'b100);
        chk("pixel_count", npix, n);
        chk("issue_count", issued, n);
    endtask

    initial begin
        int fv, dc, ne, np, popped;
        vecs[0] = '{0,   100, -1, 0, -1, 1,   0};
        vecs[1] = '{196, 100, -1, 0, 3,  199, 2};
        vecs[2] = '{196, 50,  -1, 0, -1, -1,  2};
        vecs[3] = '{100, 100, -1, 1, 3,  103, 2};
        vecs[4] = '{100, 50,  -1, 1, -1, -1,  2};
        vecs[5] = '{98,  100, -1, 1, 3,  101, 1};
        vecs[6] = '{1,   100, -1, 1, 3,  4,   1};
        vecs[7] = '{1,   30,  -1, 1, -1, -1,  1};
        vecs[8] = '{197, 70,  -1, 1, -1, -1,  3};
        vecs[9] = '{196, 100, 40, 0, 3,  199, 2};

        rst = 1'b1; i_start = 1'b0; i_num_cnt = '0; i_ready = 1'b0;
        fill_mem(0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_state",
            {o_idle, o_valid, o_done, b1_ce2, b1_we2, o_sof, o_eol, o_eof},
            8'b1000_0000);
        chk("reset_data", {o_data, b1_d2}, '0);

        for (int v = 0; v < 10; v++) begin
            fill_mem(vecs[v].rand_mem);
            run_frame(vecs[v].n, vecs[v].pct, vecs[v].restart_at, fv, dc, ne, np);
            if (vecs[v].exp_first >= 0) chk($sformatf("first_valid_v%0d", v), fv, vecs[v].exp_first);
            if (vecs[v].exp_done >= 0)  chk($sformatf("done_cycle_v%0d", v), dc, vecs[v].exp_done);
            chk($sformatf("eol_count_v%0d", v), ne, vecs[v].exp_eols);
        end

        // Reset mid-frame with data stalled in the FIFO
        fill_mem(0);
        popped = 0;
        @(posedge clk); #1;
        i_start = 1'b1; i_num_cnt = AW'(196); i_ready = 1'b1;
        for (int c = 0; c < 200 && popped < 50; c++) begin
            @(negedge clk);
            if (o_valid && i_ready) popped++;
            @(posedge clk); #1;
            i_start = 1'b0;
        end
        chk("pixels_before_reset", popped, 50);
        i_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_reset_state", {o_valid, o_idle, b1_ce2, o_done}, 4'b0100);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post_reset_quiet", {o_valid, o_idle, b1_ce2, o_done}, 4'b0100);
        end
        run_frame(120, 60, -1, fv, dc, ne, np);
        chk("restart_eols", ne, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sobel_frame_streamer.md
Name: sobel_frame_streamer

Overview:
Reads a completed Sobel result frame out of BRAM1 through its second port and streams it, pixel by pixel, over a valid/ready interface toward display or DMA logic. It is the consumer end of the Sobel FSM's BRAM1 write path. It starts when the FSM signals frame done, tags each pixel with start-of-frame, end-of-line and end-of-frame markers, and absorbs the BRAM's 1-cycle read latency with a 2-entry output FIFO, so downstream backpressure never loses or duplicates data.

Parameters:
DATA_WIDTH, 8, pixel width
ADDR_WIDTH, 12, BRAM1 address width
LINE_WIDTH, 98, pixels per output line (IMAGE_WIDTH-2 after edge trim)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_start  in  1  one-cycle pulse: BRAM1 frame ready (driven from Sobel FSM o_done)
i_num_cnt  in  ADDR_WIDTH  pixels in frame; sampled only on accepted i_start
b1_ce2  out  1  BRAM1 port-2 chip enable
b1_we2  out  1  BRAM1 port-2 write enable, tied 0
b1_addr2  out  ADDR_WIDTH  BRAM1 port-2 read address
b1_d2  out  DATA_WIDTH  tied 0 (unused)
b1_q2  in  DATA_WIDTH  BRAM1 read data, valid 1 cycle after ce
o_valid  out  1  output pixel valid
i_ready  in  1  downstream ready
o_data  out  DATA_WIDTH  pixel
o_sof  out  1  first pixel of frame
o_eol  out  1  last pixel of a line
o_eof  out  1  last pixel of frame
o_idle  out  1  state==IDLE
o_done  out  1  one-cycle pulse after last pixel handshaked

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset: state IDLE; all outputs 0 except o_idle=1; FIFO empty; counters 0; in-flight flag 0.
- States: IDLE, STREAM, DRAIN, DONE.
  - IDLE -> STREAM on i_start with i_num_cnt!=0; latch num_cnt, rd_addr=0, out_cnt=0, col=0.
  - IDLE -> DONE on i_start with i_num_cnt==0; no reads, no o_valid.
  - STREAM -> DRAIN when the read issued at address num_cnt-1 has been issued (rd_addr==num_cnt).
  - DRAIN -> DONE on the cycle the last pixel (o_eof) handshakes.
  - DONE -> IDLE unconditionally; o_done=1 only in DONE.
- i_start outside IDLE is ignored; i_num_cnt changes mid-frame are ignored.
- Read issue (STREAM only):
  - b1_ce2=1 when rd_addr<num_cnt and (occ + inflight - pop) < 2.
  - occ = FIFO entries 0..2; inflight = read issued in the previous cycle; pop = o_valid & i_ready.
  - b1_addr2=rd_addr; rd_addr increments on each issue.
- Capture: the cycle after an issue, b1_q2 is written into the FIFO tail, with markers computed from the capture index.
- FIFO never overflows by construction. Overflow is a design bug; verification asserts it.
- Output: o_valid = FIFO non-empty. o_data, o_sof, o_eol and o_eof come from the FIFO head and are held stable while o_valid & !i_ready.
- Markers, using capture index k and column counter col:
  - o_sof = (k==0).
  - o_eol = (col==LINE_WIDTH-1) or o_eof; col wraps to 0 after eol.
  - o_eof = (k==num_cnt-1).
  - A partial last line gets eol together with eof.
- Latency: i_start at cycle 0 -> STREAM cycle 1, first read cycle 1, capture cycle 2, o_valid cycle 3.
- Throughput: with i_ready held 1, one pixel per clock with no bubbles after the first pixel.
- Backpressure: if i_ready drops, issue stops within one cycle. At most 2 entries are buffered; streaming resumes at full rate the cycle i_ready returns.
- Simultaneous push and pop: occupancy unchanged and data order preserved.
- Widths: num_cnt max 2^ADDR_WIDTH-1; all comparisons are ADDR_WIDTH-bit unsigned.
- rst asserted mid-frame: the next cycle is in IDLE with FIFO flushed, o_valid=0, and no o_done. Any in-flight read data is discarded.

Test Plan:
1. Reset, then i_start with i_num_cnt=0 -> o_done pulses at cycle 1, no b1_ce2, no o_valid, back to IDLE at cycle 2.
2. BRAM1 preloaded with addr[7:0]; i_num_cnt=196, LINE_WIDTH=98, i_ready=1 -> o_valid from cycle 3 for 196 consecutive cycles, data 0..195 (mod 256), o_sof on pixel 0, o_eol on pixels 97 and 195, o_eof on 195, o_done the following cycle.
3. Same frame with i_ready toggling pseudo-randomly (50%) -> identical data/marker sequence, no duplicates or drops, FIFO occupancy never exceeds 2, o_data stable while stalled.
4. i_num_cnt=100, LINE_WIDTH=98 -> o_eol on pixels 97 and 99; pixel 99 also carries o_eof.
5. Second i_start pulse issued mid-frame with a different count -> ignored; frame completes with the original count; a later i_start in IDLE starts a new frame with o_sof set.
6. rst asserted after 50 pixels with i_ready=0 -> next cycle o_valid=0, o_idle=1, b1_ce2=0, no o_done; a fresh i_start restarts from address 0.
